ncl_count_capture32: RTL

Clocked, downstream consumer stage for the 32-digit dual-rail NCL counter. It samples the counter's 64-rail output wavefront, detects complete DATA and complete NULL, and drives the counter's per-digit completion inputs to close the NCL handshake. Each captured DATA wavefront is converted to a 32-bit binary word and offered on a valid/ready interface to the synchronous logic downstream.

---
 rtl/ncl_count_capture32.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ncl_count_capture32.sv
// Clocked consumer for a 32-digit dual-rail NCL counter; captures DATA wavefronts to a valid/ready word.
// Optional NCL_CAPTURE_SEQ_CHECK_EN flags captured words that are not previous+1.
module ncl_count_capture32 (
    input  logic        clk,
    input  logic        init_n,
    input  logic [63:0] count,
    output logic [31:0] countCOMP,
    output logic [31:0] cnt_q,
    output logic        cnt_vld,
    input  logic        cnt_rdy,
    output logic        rail_err,
    output logic        seq_err
);
    typedef enum logic {
        REQ_DATA = 1'b0,
        REQ_NULL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_s1;
    logic [63:0] r_s;
    logic [63:0] r_s_d;
    logic [31:0] r_q;
    logic        r_vld;
    logic        r_rail_err;
    logic [31:0] w_d1;
    logic [31:0] w_d0;
    logic        w_all_data;
    logic        w_all_null;
    logic        w_bad;
    logic        w_stable;
    logic        w_free;
    logic        w_capture;

    always_comb begin
        w_d1 = '0;
        w_d0 = '0;
        for (int i = 0; i < 32; i++) begin
            w_d1[i] = r_s[2*i+1];
            w_d0[i] = r_s[2*i];
        end
    end

    assign w_all_data = &(w_d1 ^ w_d0);
    assign w_all_null = ~|r_s;
    assign w_bad      = |(w_d1 & w_d0);
    assign w_stable   = (r_s == r_s_d);
    assign w_free     = !r_vld || cnt_rdy;

    // count is asynchronous to clk: two-flop sync, third stage for stability
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_s1  <= '0;
            r_s   <= '0;
            r_s_d <= '0;
        end else begin
            r_s1  <= count;
            r_s   <= r_s1;
            r_s_d <= r_s;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) r_state <= REQ_DATA;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        unique case (r_state)
            REQ_DATA: begin
                if (w_all_data && w_stable && !w_bad && w_free) begin
                    w_capture = 1'b1;
                    w_next    = REQ_NULL;
                end
            end
            REQ_NULL: begin
                if (w_all_null && w_stable) w_next = REQ_DATA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_q        <= '0;
            r_vld      <= 1'b0;
            r_rail_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_q   <= w_d1;
                r_vld <= 1'b1;
            end else if (r_vld && cnt_rdy) begin
                r_vld <= 1'b0;
            end
            if (w_bad) r_rail_err <= 1'b1;
        end
    end

`ifdef NCL_CAPTURE_SEQ_CHECK_EN
    logic r_have;
    logic r_seq_err;

    // r_q still holds the previous capture when the next one is taken
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_have    <= 1'b0;
            r_seq_err <= 1'b0;
        end else if (w_capture) begin
            r_have <= 1'b1;
            if (r_have && (w_d1 != r_q + 32'd1)) r_seq_err <= 1'b1;
        end
    end

    assign seq_err = r_seq_err;
`else
    assign seq_err = 1'b0;
`endif

    assign countCOMP = {32{r_state == REQ_NULL}};
    assign cnt_q     = r_q;
    assign cnt_vld   = r_vld;
    assign rail_err  = r_rail_err;
endmodule
